// File: rtl/baud_tick_gen.sv
// Baud tick generator: programmable divisor to a one-cycle oversample strobe plus a baud strobe
// every 2^OS_LOG2 oversample strobes. Define BAUD_FRAC_EN to add the fractional divisor.
module baud_tick_gen #(
    parameter int DIV_W     = 16,
    parameter int OS_LOG2   = 4,
    parameter int RESET_DIV = 54,
    parameter int FRAC_W    = 4
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic [DIV_W-1:0]   div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0]  frac_in,
`endif
    input  logic               div_load,
    input  logic               resync,
    output logic               os_tick_out,
    output logic               baud_tick_out,
    output logic [OS_LOG2-1:0] os_phase_out,
    output logic [DIV_W-1:0]   div_active_out
);

    localparam logic [DIV_W-1:0]   RESET_DIV_V = DIV_W'(RESET_DIV);
    localparam logic [OS_LOG2-1:0] PHASE_MAX   = '1;

    logic [DIV_W-1:0]   pend_div_q, pend_div_d;
    logic [DIV_W-1:0]   act_div_q, act_div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [OS_LOG2-1:0] phase_q, phase_d;
    logic               os_tick_q, os_tick_d;
    logic               baud_tick_q, baud_tick_d;
    logic               ext;
    logic [DIV_W-1:0]   eff;
    logic [DIV_W:0]     limit;
    logic               boundary;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    assign ext = ext_q;
`else
    // No fractional carry in this build: every period is exactly eff.
    assign ext = |{FRAC_W{1'b0}};
`endif

    assign eff      = (act_div_q == '0) ? DIV_W'(1) : act_div_q;
    assign limit    = {1'b0, eff} - (DIV_W+1)'(1) + {{DIV_W{1'b0}}, ext};
    assign boundary = start && !resync && ({1'b0, cnt_q} == limit);

    always_comb begin
        pend_div_d  = pend_div_q;
        act_div_d   = act_div_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        os_tick_d   = 1'b0;
        baud_tick_d = 1'b0;
`ifdef BAUD_FRAC_EN
        pend_frac_d = pend_frac_q;
        act_frac_d  = act_frac_q;
        acc_d       = acc_q;
        ext_d       = ext_q;
        if (div_load) pend_frac_d = frac_in;
`endif
        if (div_load) pend_div_d = div_in;

        if (!start || resync) begin
            // Restart the bit: the pending divisor is adopted while nothing is being timed.
            cnt_d     = '0;
            phase_d   = '0;
            act_div_d = pend_div_q;
`ifdef BAUD_FRAC_EN
            act_frac_d = pend_frac_q;
            acc_d      = '0;
            ext_d      = 1'b0;
`endif
        end else if (boundary) begin
            cnt_d       = '0;
            os_tick_d   = 1'b1;
            baud_tick_d = (phase_q == PHASE_MAX);
            phase_d     = phase_q + OS_LOG2'(1);
            act_div_d   = div_load ? div_in : pend_div_q;
`ifdef BAUD_FRAC_EN
            act_frac_d     = div_load ? frac_in : pend_frac_q;
            {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
`endif
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend_div_q  <= RESET_DIV_V;
            act_div_q   <= RESET_DIV_V;
            cnt_q       <= '0;
            phase_q     <= '0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
`ifdef BAUD_FRAC_EN
            pend_frac_q <= '0;
            act_frac_q  <= '0;
            acc_q       <= '0;
            ext_q       <= 1'b0;
`endif
        end else begin
            pend_div_q  <= pend_div_d;
            act_div_q   <= act_div_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            os_tick_q   <= os_tick_d;
            baud_tick_q <= baud_tick_d;
`ifdef BAUD_FRAC_EN
            pend_frac_q <= pend_frac_d;
            act_frac_q  <= act_frac_d;
            acc_q       <= acc_d;
            ext_q       <= ext_d;
`endif
        end
    end

    assign os_tick_out    = os_tick_q;
    assign baud_tick_out  = baud_tick_q;
    assign os_phase_out   = phase_q;
    assign div_active_out = act_div_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed timing scenarios plus random traffic against a
// period-countdown reference model.
module tb_baud_tick_gen;
    localparam int DIV_W     = 16;
    localparam int OS_LOG2   = 4;
    localparam int RESET_DIV = 54;
    localparam int FRAC_W    = 4;
    localparam int NPH       = 1 << OS_LOG2;
    localparam int FSCALE    = 1 << FRAC_W;
`ifdef BAUD_FRAC_EN
    localparam bit HAS_FRAC = 1'b1;
`else
    localparam bit HAS_FRAC = 1'b0;
`endif

    logic               clk_in = 1'b0;
    logic               rst, start, div_load, resync;
    logic [DIV_W-1:0]   div_in;
    logic [FRAC_W-1:0]  frac_in;
    logic               os_tick_out, baud_tick_out;
    logic [OS_LOG2-1:0] os_phase_out;
    logic [DIV_W-1:0]   div_active_out;

    always #5 clk_in = ~clk_in;

    baud_tick_gen #(
        .DIV_W(DIV_W), .OS_LOG2(OS_LOG2), .RESET_DIV(RESET_DIV), .FRAC_W(FRAC_W)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .start          (start),
        .div_in         (div_in),
`ifdef BAUD_FRAC_EN
        .frac_in        (frac_in),
`endif
        .div_load       (div_load),
        .resync         (resync),
        .os_tick_out    (os_tick_out),
        .baud_tick_out  (baud_tick_out),
        .os_phase_out   (os_phase_out),
        .div_active_out (div_active_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: counts down the cycles left in the current strobe period.
    int m_act, m_pend, m_actf, m_pendf, m_acc, m_left, m_phase;
    bit m_os, m_baud;

    function automatic int eff_of(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic model_step();
        int sum, carry, new_f;
        new_f = HAS_FRAC ? int'(frac_in) : 0;
        if (rst) begin
            m_act = RESET_DIV; m_pend = RESET_DIV; m_actf = 0; m_pendf = 0;
            m_acc = 0; m_phase = 0; m_os = 0; m_baud = 0;
            m_left = eff_of(RESET_DIV);
            return;
        end
        if (!start || resync) begin
            m_act = m_pend; m_actf = m_pendf;
            m_acc = 0; m_phase = 0; m_os = 0; m_baud = 0;
            m_left = eff_of(m_act);
        end else if (m_left == 1) begin
            m_os    = 1;
            m_baud  = (m_phase == NPH - 1);
            m_phase = (m_phase + 1) % NPH;
            sum     = m_acc + m_actf;
            carry   = sum / FSCALE;
            m_acc   = sum % FSCALE;
            m_act   = div_load ? int'(div_in) : m_pend;
            m_actf  = div_load ? new_f : m_pendf;
            m_left  = eff_of(m_act) + carry;
        end else begin
            m_left--;
            m_os = 0; m_baud = 0;
        end
        if (div_load) begin
            m_pend  = int'(div_in);
            m_pendf = new_f;
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later, pulses cleared.
    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
        check_eq("os_tick", 32'(os_tick_out), 32'(m_os));
        check_eq("baud_tick", 32'(baud_tick_out), 32'(m_baud));
        check_eq("os_phase", 32'(os_phase_out), 32'(m_phase));
        check_eq("div_active", 32'(div_active_out), 32'(m_act));
        div_load = 1'b0;
        resync   = 1'b0;
    endtask

    task automatic wait_os(input string tag, input int limit, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!os_tick_out && n < limit);
        if (!os_tick_out) check_eq({tag, "_timeout"}, 32'(os_tick_out), 32'd1);
    endtask

    int n, total, n55;

    initial begin
        rst = 1'b1; start = 1'b0; div_load = 1'b0; resync = 1'b0;
        div_in = '0; frac_in = '0;
        m_act = 0; m_pend = 0; m_actf = 0; m_pendf = 0; m_acc = 0;
        m_left = 1; m_phase = 0; m_os = 0; m_baud = 0;
        cycle();
        cycle();
        check_eq("rst_os", 32'(os_tick_out), 32'd0);
        check_eq("rst_div", 32'(div_active_out), 32'(RESET_DIV));
        rst = 1'b0;
        cycle();

        // Default divisor: first strobe on the 54th edge, baud on the 864th.
        start = 1'b1;
        wait_os("first_os", 200, n);
        check_eq("first_os_edges", 32'(n), 32'd54);
        total = n;
        while (!baud_tick_out && total < 2000) begin
            cycle();
            total++;
        end
        check_eq("first_baud_edges", 32'(total), 32'd864);

        // Load mid-period: old period completes, then period 3.
        n = 0;
        do begin
            if (n == 20) begin div_in = 16'd3; div_load = 1'b1; end
            cycle();
            n++;
        end while (!os_tick_out && n < 200);
        check_eq("load_old_period", 32'(n), 32'd54);
        check_eq("load_new_active", 32'(div_active_out), 32'd3);
        wait_os("new_period", 50, n);
        check_eq("new_period_len", 32'(n), 32'd3);

        // Divisors 0 and 1 both strobe every cycle.
        div_in = 16'd0; div_load = 1'b1;
        repeat (40) cycle();
        div_in = 16'd1; div_load = 1'b1;
        repeat (40) cycle();
        check_eq("div1_os_high", 32'(os_tick_out), 32'd1);

        // Resync 20 cycles into a 54 period.
        div_in = 16'd54; div_load = 1'b1;
        wait_os("to54_a", 50, n);
        wait_os("to54_b", 200, n);
        repeat (19) cycle();
        resync = 1'b1;
        cycle();
        check_eq("resync_no_strobe", 32'(os_tick_out), 32'd0);
        wait_os("after_resync", 200, n);
        check_eq("resync_period", 32'(n), 32'd54);
        check_eq("resync_phase", 32'(os_phase_out), 32'd1);

        // Drop start mid-bit, then restart.
        repeat (70) cycle();
        start = 1'b0;
        cycle();
        check_eq("stop_phase", 32'(os_phase_out), 32'd0);
        check_eq("stop_keep_div", 32'(div_active_out), 32'd54);
        repeat (5) cycle();
        start = 1'b1;
        wait_os("restart", 200, n);
        check_eq("restart_first_os", 32'(n), 32'd54);

`ifdef BAUD_FRAC_EN
        // Fractional 54 + 4/16: 16 strobes span 868 cycles, four periods of 55.
        div_in = 16'd54; frac_in = 4'd4; div_load = 1'b1;
        cycle();
        resync = 1'b1;
        cycle();
        wait_os("frac_first", 200, n);
        total = 0; n55 = 0;
        for (int i = 0; i < 16; i++) begin
            wait_os("frac_period", 200, n);
            total += n;
            if (n == 55) n55++;
        end
        check_eq("frac_total", 32'(total), 32'd868);
        check_eq("frac_n55", 32'(n55), 32'd4);
`endif

        // Random traffic.
        for (int i = 0; i < 15000; i++) begin
            rst      = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 99) == 0) start = ~start;
            if (!start && $urandom_range(0, 9) == 0) start = 1'b1;
            resync   = ($urandom_range(0, 149) == 0);
            div_load = ($urandom_range(0, 59) == 0);
            div_in   = ($urandom_range(0, 7) == 0) ? DIV_W'($urandom_range(20, 60))
                                                   : DIV_W'($urandom_range(0, 7));
            frac_in  = FRAC_W'($urandom_range(0, FSCALE - 1));
            cycle();
        end

        // Reset mid-run returns every output to reset values.
        start = 1'b1; div_in = 16'd2; div_load = 1'b1;
        repeat (30) cycle();
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_os", 32'(os_tick_out), 32'd0);
        check_eq("mid_rst_baud", 32'(baud_tick_out), 32'd0);
        check_eq("mid_rst_phase", 32'(os_phase_out), 32'd0);
        check_eq("mid_rst_div", 32'(div_active_out), 32'(RESET_DIV));
        rst = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
